// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle shift sequencer.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_RSV = 2'b10,
        SH_SRA = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } shift_state_e;

endpackage

// File: rtl/shift_step_unit.sv
// Combinational step shifter: moves the accumulator by at most MAX_STEP positions.
module shift_step_unit
    import shift_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_STEP = 8
) (
    input  logic [XLEN-1:0]                  acc_i,
    input  shift_op_e                        op_i,
    input  logic [$clog2(MAX_STEP+1)-1:0]    step_i,
    output logic [XLEN-1:0]                  acc_o
);

    // SH_RSV falls into the default branch and behaves as a left shift.
    always_comb begin
        acc_o = acc_i << step_i;
        case (op_i)
            SH_SRL:  acc_o = acc_i >> step_i;
            SH_SRA:  acc_o = $signed(acc_i) >>> step_i;
            default: acc_o = acc_i << step_i;
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Shift sequencer: accepts one SLL/SRL/SRA, walks it through the step shifter, holds the result.
//  state    | meaning
//  ST_IDLE  | ready for a request, no result pending
//  ST_SHIFT | applying up to MAX_STEP positions per cycle until rem reaches zero
//  ST_DONE  | result valid on rd_o, waiting for the consumer
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_STEP = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] rd_o,
    output logic            busy_o
);

    localparam int SHW = $clog2(XLEN);
    localparam int SW  = $clog2(MAX_STEP + 1);

    shift_state_e    state_q;
    shift_op_e       op_q;
    logic [XLEN-1:0] acc_q;
    logic [SHW-1:0]  rem_q;
    logic            valid_q;
    logic            ready_q;
    logic            busy_q;

    logic [SHW:0]    rem_ext;
    logic [SHW:0]    max_ext;
    logic [SHW:0]    step_full;
    logic [SW-1:0]   step_d;
    logic [SHW-1:0]  rem_d;
    logic [XLEN-1:0] acc_d;
    logic            rs2_hi_unused;

    assign rs2_hi_unused = ^rs2_i[XLEN-1:SHW];

    // One extra bit so MAX_STEP=XLEN still compares correctly against rem.
    always_comb begin
        rem_ext   = {1'b0, rem_q};
        max_ext   = (SHW+1)'(MAX_STEP);
        step_full = (rem_ext < max_ext) ? rem_ext : max_ext;
        step_d    = SW'(step_full);
        rem_d     = rem_q - step_full[SHW-1:0];
    end

    shift_step_unit #(
        .XLEN     (XLEN),
        .MAX_STEP (MAX_STEP)
    ) u_step (
        .acc_i  (acc_q),
        .op_i   (op_q),
        .step_i (step_d),
        .acc_o  (acc_d)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            op_q    <= SH_SLL;
            acc_q   <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else if (flush_i) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (valid_i) begin
                        acc_q   <= rs1_i;
                        op_q    <= shift_op_e'(op_i);
                        rem_q   <= rs2_i[SHW-1:0];
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (rs2_i[SHW-1:0] == '0) begin
                            state_q <= ST_DONE;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    acc_q <= acc_d;
                    rem_q <= rem_d;
                    if (rem_d == '0) begin
                        state_q <= ST_DONE;
                        valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (ready_i) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_o    = acc_q;
    assign valid_o = valid_q;
    assign ready_o = ready_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: three instances with MAX_STEP of 8, 1 and 32.
`timescale 1ns/1ps
module tb_shift_seq_ctrl;

    localparam int NL = 3;
    localparam int MS [NL] = '{8, 1, 32};

    typedef struct packed {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i [NL];
    logic        ready_o [NL];
    logic [1:0]  op_i    [NL];
    logic [31:0] rs1_i   [NL];
    logic [31:0] rs2_i   [NL];
    logic        flush_i [NL];
    logic        valid_o [NL];
    logic        ready_i [NL];
    logic [31:0] rd_o    [NL];
    logic        busy_o  [NL];

    logic        rnd_rdy [NL];
    logic        dir_rdy = 1'b1;
    logic        rnd_phase = 1'b0;
    bit          vprev [NL];
    exp_t        sb_q [NL][$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NL; g++) begin : g_dut
        assign ready_i[g] = rnd_phase ? rnd_rdy[g] : dir_rdy;
        shift_seq_ctrl #(.XLEN(32), .MAX_STEP(MS[g])) u_dut (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .valid_i (valid_i[g]),
            .ready_o (ready_o[g]),
            .op_i    (op_i[g]),
            .rs1_i   (rs1_i[g]),
            .rs2_i   (rs2_i[g]),
            .flush_i (flush_i[g]),
            .valid_o (valid_o[g]),
            .ready_i (ready_i[g]),
            .rd_o    (rd_o[g]),
            .busy_o  (busy_o[g])
        );
    end

    always @(posedge clk) begin
        for (int l = 0; l < NL; l++) rnd_rdy[l] <= ($urandom_range(0, 3) != 0);
    end

    // Reference: the whole shift in one step, SRA built from a logical shift plus sign mask.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned s;
        logic [31:0] ones;
        s = b % 32;
        ones = 32'hFFFF_FFFF;
        case (op)
            2'b01:   return a >> s;
            2'b11:   return (a >> s) | (a[31] ? ~(ones >> s) : 32'h0);
            default: return a << s;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Issues one request on lane l; returns #1 after the accepting edge.
    task automatic do_op(input int l, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit push);
        bit ok;
        int s;
        exp_t e;
        op_i[l] = op; rs1_i[l] = a; rs2_i[l] = b; valid_i[l] = 1'b1;
        ok = 0;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge clk);
            if (ready_o[l] && !flush_i[l]) ok = 1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout lane=%0d ready_o=%b exp=1", l, ready_o[l]);
            valid_i[l] = 1'b0;
            return;
        end
        s = b % 32;
        e.res = model(op, a, b);
        e.cyc = cyc + 1 + (s + MS[l] - 1) / MS[l];
        if (push) sb_q[l].push_back(e);
        @(posedge clk);
        #1;
        valid_i[l] = 1'b0;
        op_i[l] = 2'($urandom); rs1_i[l] = $urandom; rs2_i[l] = $urandom;
    endtask

    task automatic drain(input int l);
        for (int n = 0; n < 300 && sb_q[l].size() != 0; n++) @(negedge clk);
        chk("drain_pending", sb_q[l].size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_lane(input int l);
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 100; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            do_op(l, op, a, b, 1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Monitor: every valid_o cycle is compared; latency checked on the first valid cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            for (int l = 0; l < NL; l++) vprev[l] = 0;
        end else begin
            for (int l = 0; l < NL; l++) begin
                if (valid_o[l]) begin
                    checks++;
                    if (sb_q[l].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_valid lane=%0d rd_o=%h valid_o=1 exp=0", l, rd_o[l]);
                    end else begin
                        e = sb_q[l][0];
                        if (rd_o[l] !== e.res) begin
                            errors++;
                            $display("FAIL rd lane=%0d got=%h exp=%h", l, rd_o[l], e.res);
                        end
                        if (!vprev[l]) begin
                            checks++;
                            if (cyc != e.cyc) begin
                                errors++;
                                $display("FAIL latency lane=%0d got_cycle=%0d exp_cycle=%0d", l, cyc, e.cyc);
                            end
                        end
                        if (ready_i[l]) void'(sb_q[l].pop_front());
                    end
                    vprev[l] = !ready_i[l];
                end else begin
                    vprev[l] = 0;
                end
            end
        end
    end

    initial begin
        logic [31:0] held;
        bit          seen;
        for (int l = 0; l < NL; l++) begin
            valid_i[l] = 0; op_i[l] = 0; rs1_i[l] = 0; rs2_i[l] = 0; flush_i[l] = 0;
        end
        #12;
        for (int l = 0; l < NL; l++) begin
            chk("reset_rd", rd_o[l], 32'h0);
            chk("reset_vld_rdy_bsy", {29'b0, valid_o[l], ready_o[l], busy_o[l]}, 32'b010);
        end
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases on the MAX_STEP=8 lane
        do_op(0, 2'b00, 32'h0000_0001, 32'd31, 1); drain(0);
        do_op(0, 2'b11, 32'h8000_0000, 32'd4, 1);  drain(0);
        do_op(0, 2'b01, 32'h8000_0000, 32'd4, 1);  drain(0);
        do_op(0, 2'b00, 32'h1234_5678, 32'h20, 1); drain(0);

        // Consumer stalls in DONE while a new request is offered
        dir_rdy = 1'b0;
        do_op(0, 2'b00, 32'h0000_00F0, 32'd4, 1);
        seen = 0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (valid_o[0]) seen = 1;
        end
        chk("stall_valid_seen", {31'b0, seen}, 32'd1);
        held = rd_o[0];
        valid_i[0] = 1'b1; op_i[0] = 2'b01; rs1_i[0] = 32'hDEAD_BEEF; rs2_i[0] = 32'd3;
        repeat (5) begin
            @(negedge clk);
            chk("stall_rd", rd_o[0], held);
            chk("stall_vld_rdy_bsy", {29'b0, valid_o[0], ready_o[0], busy_o[0]}, 32'b101);
        end
        @(posedge clk);
        #1 dir_rdy = 1'b1;
        @(posedge clk);
        #1 valid_i[0] = 1'b0;
        @(negedge clk);
        chk("release_vld_rdy_bsy", {29'b0, valid_o[0], ready_o[0], busy_o[0]}, 32'b010);
        @(posedge clk);
        #1;

        // Flush in the second SHIFT cycle
        do_op(0, 2'b00, 32'h0000_0001, 32'd31, 0);
        @(posedge clk);
        #1 flush_i[0] = 1'b1;
        @(posedge clk);
        #1 flush_i[0] = 1'b0;
        @(negedge clk);
        chk("flush_vld_rdy_bsy", {29'b0, valid_o[0], ready_o[0], busy_o[0]}, 32'b010);
        repeat (6) @(posedge clk);
        #1;
        do_op(0, 2'b01, 32'hFFFF_FFFF, 32'd1, 1); drain(0);

        // Flush beats a simultaneous request
        valid_i[0] = 1'b1; flush_i[0] = 1'b1; op_i[0] = 2'b00; rs1_i[0] = 32'h1; rs2_i[0] = 32'd2;
        @(posedge clk);
        #1 valid_i[0] = 1'b0; flush_i[0] = 1'b0;
        @(negedge clk);
        chk("flush_vs_valid", {29'b0, valid_o[0], ready_o[0], busy_o[0]}, 32'b010);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of SHIFT
        do_op(0, 2'b00, 32'h0000_0001, 32'd31, 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_rd", rd_o[0], 32'h0);
        chk("midreset_vld_rdy_bsy", {29'b0, valid_o[0], ready_o[0], busy_o[0]}, 32'b010);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op(0, 2'b11, 32'h8000_0000, 32'd4, 1); drain(0);

        // Random traffic on every lane with a randomly stalling consumer
        rnd_phase = 1'b1;
        fork
            run_lane(0);
            run_lane(1);
            run_lane(2);
        join
        for (int n = 0; n < 400 && (sb_q[0].size() + sb_q[1].size() + sb_q[2].size()) != 0; n++)
            @(negedge clk);
        for (int l = 0; l < NL; l++) chk("final_pending", sb_q[l].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
